// File: rtl/memory_read_arbiter_if.sv
// Downstream memory read channel between the arbiter and the memory controller.
// The arbiter drives the request side; the controller answers with ready/data.
interface memory_read_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  down_read_valid;
  logic                  down_read_ready;
  logic [ADDR_WIDTH-1:0] down_read_addr;
  logic [DATA_WIDTH-1:0] down_read_data;

  modport master (
    output down_read_valid,
    output down_read_addr,
    input  down_read_ready,
    input  down_read_data
  );

  modport slave (
    input  down_read_valid,
    input  down_read_addr,
    output down_read_ready,
    output down_read_data
  );
endinterface

// File: rtl/memory_read_arbiter.sv
// Round-robin arbiter sharing one memory read channel between NUM_REQ requesters,
// with an idle gap between reads and a watchdog that aborts hung reads.
module memory_read_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_error,
  output logic [DATA_WIDTH-1:0]         req_data,
  output logic [IDW-1:0]                grant_id,
  memory_read_arbiter_if.master         down
);

  localparam int WDW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [IDW-1:0]          rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    valid_q, valid_d;
  logic [WDW-1:0]          wd_q, wd_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [NUM_REQ-1:0]      err_q, err_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [2*NUM_REQ-1:0]    dbl;
  logic [2*NUM_REQ-1:0]    rot;
  logic                    found;
  logic [IDW-1:0]          pick;
  logic [ADDR_WIDTH-1:0]   pick_addr;

  // Rotate the request vector so bit 0 is the requester at rr_q.
  always_comb begin
    int pi;
    dbl   = {req_valid, req_valid};
    rot   = dbl >> rr_q;
    found = 1'b0;
    pi    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pi    = int'(rr_q) + i;
      end
    end
    if (pi >= NUM_REQ) pi = pi - NUM_REQ;
    pick      = IDW'(pi);
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == pick)
        pick_addr = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    wd_d    = wd_q;
    done_d  = '0;
    err_d   = '0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          addr_d  = pick_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        valid_d = 1'b1;
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (down.down_read_ready) begin
          done_d[grant_q] = 1'b1;
          data_d          = down.down_read_data;
          valid_d         = 1'b0;
          state_d         = GAP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          data_d          = '0;
          valid_d         = 1'b0;
          state_d         = GAP;
        end
      end
      GAP: begin
        if (grant_q == IDW'(NUM_REQ - 1)) rr_d = '0;
        else                              rr_d = grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      wd_q    <= '0;
      done_q  <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign down.down_read_valid = valid_q;
  assign down.down_read_addr  = addr_q;
  assign req_done             = done_q;
  assign req_error            = err_q;
  assign req_data             = data_q;
  assign grant_id             = grant_q;

endmodule
